fetch_stage: RTL and testbench

Instruction fetch stage of the REDUX-V core, directly upstream of `instruction_memory`. Owns the program counter, drives the memory address, pairs each synchronous-read instruction with its address, and presents a registered fetch/decode bundle (`if_instruction`, `if_pc`, `if_valid`) to decode. Handles sequential fetch, taken-branch redirect with flush, and downstream stall without losing the in-flight instruction.

---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/program_counter.sv | 35 +++
 rtl/fetch_stage.sv | 89 ++++++++
 tb/tb_fetch_stage.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and default sizing for the REDUX-V instruction fetch stage.
package fetch_stage_pkg;

    localparam int DEFAULT_BITS        = 8;
    localparam int DEFAULT_MEMORY_BITS = 8;
    localparam int DEFAULT_RESET_PC    = 0;

    // EMPTY: the value on `instruction` answers no useful address.
    typedef enum logic {
        EMPTY  = 1'b0,
        STREAM = 1'b1
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_ADVANCE  = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_op_e;

endpackage

// File: rtl/program_counter.sv
// Holds the next-issue address; advances modulo 2^MEMORY_BITS, redirects or holds.
module program_counter
    import fetch_stage_pkg::*;
#(
    parameter int MEMORY_BITS = DEFAULT_MEMORY_BITS,
    parameter int RESET_PC    = DEFAULT_RESET_PC
) (
    input  logic                   clk,
    input  logic                   reset,
    input  pc_op_e                 op_i,
    input  logic [MEMORY_BITS-1:0] target_i,
    output logic [MEMORY_BITS-1:0] pc_o
);

    localparam logic [MEMORY_BITS-1:0] RESET_ADDR = MEMORY_BITS'(RESET_PC);

    logic [MEMORY_BITS-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        case (op_i)
            PC_ADVANCE:  pc_d = pc_q + MEMORY_BITS'(1);
            PC_REDIRECT: pc_d = target_i;
            default:     pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_q <= RESET_ADDR;
        else       pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: drives the synchronous-read memory address, pairs each returned
// instruction with its address and presents a registered bundle to decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int BITS        = DEFAULT_BITS,
    parameter int MEMORY_BITS = DEFAULT_MEMORY_BITS,
    parameter int RESET_PC    = DEFAULT_RESET_PC
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [MEMORY_BITS-1:0] branch_target,
    output logic [MEMORY_BITS-1:0] pc,
    input  logic [BITS-1:0]        instruction,
    output logic [BITS-1:0]        if_instruction,
    output logic [MEMORY_BITS-1:0] if_pc,
    output logic                   if_valid
);

    fetch_state_e           state_q, state_d;
    pc_op_e                 pc_op;
    logic [MEMORY_BITS-1:0] pc_q;
    logic [MEMORY_BITS-1:0] inflight_pc_q, inflight_pc_d;
    logic                   inflight_valid_q;
    logic [BITS-1:0]        if_instruction_q, if_instruction_d;
    logic [MEMORY_BITS-1:0] if_pc_q, if_pc_d;
    logic                   if_valid_q, if_valid_d;

    assign inflight_valid_q = (state_q == STREAM);

    program_counter #(
        .MEMORY_BITS(MEMORY_BITS),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .reset   (reset),
        .op_i    (pc_op),
        .target_i(branch_target),
        .pc_o    (pc_q)
    );

    // While stalled, memory re-reads the in-flight address so `instruction` stays put.
    assign pc = (stall && !branch_taken && inflight_valid_q) ? inflight_pc_q : pc_q;

    always_comb begin
        state_d          = state_q;
        pc_op            = PC_ADVANCE;
        inflight_pc_d    = inflight_pc_q;
        if_instruction_d = if_instruction_q;
        if_pc_d          = if_pc_q;
        if_valid_d       = if_valid_q;
        if (branch_taken) begin
            pc_op      = PC_REDIRECT;
            state_d    = EMPTY;
            if_valid_d = 1'b0;
        end else if (stall) begin
            pc_op = PC_HOLD;
        end else begin
            inflight_pc_d    = pc_q;
            state_d          = STREAM;
            if_instruction_d = instruction;
            if_pc_d          = inflight_pc_q;
            if_valid_d       = inflight_valid_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= EMPTY;
            inflight_pc_q    <= '0;
            if_instruction_q <= '0;
            if_pc_q          <= '0;
            if_valid_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            inflight_pc_q    <= inflight_pc_d;
            if_instruction_q <= if_instruction_d;
            if_pc_q          <= if_pc_d;
            if_valid_q       <= if_valid_d;
        end
    end

    assign if_instruction = if_instruction_q;
    assign if_pc          = if_pc_q;
    assign if_valid       = if_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against an identity ROM (mem[i] = i) with synchronous read.
module tb_fetch_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic [7:0] pc;
    logic [7:0] instruction;
    logic [7:0] if_instruction;
    logic [7:0] if_pc;
    logic       if_valid;

    int checks = 0;
    int errors = 0;

    logic [7:0] rom [256];
    logic [7:0] mem_addr_q;

    initial for (int i = 0; i < 256; i++) rom[i] = 8'(i);

    always @(posedge clk) mem_addr_q <= pc;
    assign instruction = rom[mem_addr_q];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .instruction   (instruction),
        .if_instruction(if_instruction),
        .if_pc         (if_pc),
        .if_valid      (if_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then check the bundle; contents only matter when valid.
    task automatic step(input logic exp_valid, input logic [7:0] exp_pc);
        @(posedge clk);
        #1;
        check("if_valid", 32'(if_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("if_pc", 32'(if_pc), 32'(exp_pc));
            check("if_instruction", 32'(if_instruction), 32'(exp_pc));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        #1;
        check("reset pc", 32'(pc), 32'h00);
        check("reset if_valid", 32'(if_valid), 32'h0);
        check("reset if_pc", 32'(if_pc), 32'h00);
        check("reset if_instruction", 32'(if_instruction), 32'h00);
        #11 reset = 1'b0;

        // two-edge latency after reset release
        step(1'b0, 8'h00);
        check("pc after edge1", 32'(pc), 32'h01);
        step(1'b1, 8'h00);
        step(1'b1, 8'h01);
        step(1'b1, 8'h02);

        // stream through the address wrap 0xFE -> 0xFF -> 0x00
        for (int i = 3; i <= 256; i++) step(1'b1, 8'(i));
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i));

        // 3-cycle stall on bundle 0x10
        stall = 1'b1;
        #1 check("pc during stall", 32'(pc), 32'h11);
        step(1'b1, 8'h10);
        step(1'b1, 8'h10);
        step(1'b1, 8'h10);
        stall = 1'b0;
        step(1'b1, 8'h11);
        step(1'b1, 8'h12);

        // plain redirect at bundle 0x20
        for (int i = 8'h13; i <= 8'h20; i++) step(1'b1, 8'(i));
        branch_taken = 1'b1; branch_target = 8'h80;
        step(1'b0, 8'h00);
        branch_taken = 1'b0;
        step(1'b0, 8'h00);
        step(1'b1, 8'h80);
        step(1'b1, 8'h81);

        // redirect together with stall: redirect wins, address mux ignores the stall
        branch_taken = 1'b1; stall = 1'b1; branch_target = 8'h40;
        #1 check("pc branch+stall", 32'(pc), 32'h83);
        step(1'b0, 8'h00);
        branch_taken = 1'b0; stall = 1'b0;
        step(1'b0, 8'h00);
        step(1'b1, 8'h40);
        step(1'b1, 8'h41);

        // move to 0x33 then pulse reset between edges
        branch_taken = 1'b1; branch_target = 8'h30;
        step(1'b0, 8'h00);
        branch_taken = 1'b0;
        step(1'b0, 8'h00);
        step(1'b1, 8'h30);
        step(1'b1, 8'h31);
        step(1'b1, 8'h32);
        step(1'b1, 8'h33);
        #3 reset = 1'b1;
        #1;
        check("async reset if_valid", 32'(if_valid), 32'h0);
        check("async reset if_pc", 32'(if_pc), 32'h00);
        check("async reset if_instruction", 32'(if_instruction), 32'h00);
        check("async reset pc", 32'(pc), 32'h00);
        @(posedge clk);
        #3 reset = 1'b0;
        step(1'b0, 8'h00);
        step(1'b1, 8'h00);
        step(1'b1, 8'h01);
        step(1'b1, 8'h02);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
